// File: rtl/lane_judge_scheduler.sv
// Shares one registered distance scorer among LANES arrow lanes: captures presses with a y
// snapshot, grants them round-robin, and accumulates total score, combo and max combo.
//
// state  | meaning
// IDLE   | waiting for a pending lane; grants the first pending lane at/after rr_ptr
// ISSUE  | score_req high with the granted lane's y snapshot
// WAIT   | scorer computing; its result is sampled into pts_q at the end of this cycle
// ACCUM  | retire the request, update total/combo, emit hit or miss
module lane_judge_scheduler #(
  parameter int LANES   = 4,
  parameter int Y_W     = 10,
  parameter int PTS_W   = 20,
  parameter int COMBO_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 game_active,
  input  logic                 score_clear,
  input  logic [LANES-1:0]     btn_press,
  input  logic [LANES-1:0]     lane_valid,
  input  logic [LANES*Y_W-1:0] lane_y,
  output logic                 score_req,
  output logic [Y_W-1:0]       score_y,
  input  logic [PTS_W-1:0]     score_pts,
  output logic [LANES-1:0]     arrow_clear,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic [PTS_W-1:0]     total_score,
  output logic [COMBO_W-1:0]   combo,
  output logic [COMBO_W-1:0]   max_combo,
  output logic                 busy
);
  localparam int GW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACCUM} state_t;

  state_t             state, state_nxt;
  logic [LANES-1:0]   pending;
  logic [Y_W-1:0]     snap_y [LANES];
  logic [GW-1:0]      rr_ptr, grant, grant_nxt, idx;
  logic               grant_found;
  logic [PTS_W-1:0]   pts_q;
  logic [LANES-1:0]   cap_ok, cap_set, clr_mask;
  logic               cap_miss;
  logic [PTS_W:0]     sum;
  logic [PTS_W-1:0]   total_sat;
  logic [COMBO_W-1:0] combo_inc;

  always_comb begin
    grant_found = 1'b0;
    grant_nxt   = '0;
    idx         = '0;
    for (int k = 0; k < LANES; k++) begin
      idx = GW'((int'(rr_ptr) + k) % LANES);
      if (!grant_found && pending[idx]) begin
        grant_found = 1'b1;
        grant_nxt   = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = ACCUM;
      ACCUM:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cap_ok   = btn_press & ~pending & {LANES{game_active}};
    cap_set  = cap_ok & lane_valid;
    cap_miss = |(cap_ok & ~lane_valid);
    clr_mask = '0;
    if (state == ACCUM) clr_mask[grant] = 1'b1;
    sum       = {1'b0, total_score} + {1'b0, pts_q};
    total_sat = sum[PTS_W] ? '1 : sum[PTS_W-1:0];
    combo_inc = (combo == '1) ? combo : combo + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      rr_ptr      <= '0;
      grant       <= '0;
      pts_q       <= '0;
      score_req   <= 1'b0;
      score_y     <= '0;
      arrow_clear <= '0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      total_score <= '0;
      combo       <= '0;
      max_combo   <= '0;
      for (int i = 0; i < LANES; i++) snap_y[i] <= '0;
    end else begin
      state       <= state_nxt;
      score_req   <= 1'b0;
      arrow_clear <= '0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      pending     <= (pending | cap_set) & ~clr_mask;
      for (int i = 0; i < LANES; i++)
        if (cap_set[i]) snap_y[i] <= lane_y[i*Y_W +: Y_W];

      case (state)
        IDLE: if (grant_found) begin
          grant     <= grant_nxt;
          score_req <= 1'b1;
          score_y   <= snap_y[grant_nxt];
        end
        WAIT: pts_q <= score_pts;
        ACCUM: begin
          rr_ptr <= (grant == GW'(LANES-1)) ? '0 : grant + 1'b1;
          if (pts_q != '0) begin
            total_score        <= total_sat;
            combo              <= combo_inc;
            if (combo_inc > max_combo) max_combo <= combo_inc;
            arrow_clear[grant] <= 1'b1;
            hit_pulse          <= 1'b1;
          end else begin
            combo      <= '0;
            miss_pulse <= 1'b1;
          end
        end
        default: ;
      endcase

      // A press with no live arrow breaks the combo even if ACCUM scores a hit this cycle.
      if (cap_miss) begin
        miss_pulse <= 1'b1;
        combo      <= '0;
      end
      if (score_clear) begin
        total_score <= '0;
        combo       <= '0;
        max_combo   <= '0;
      end
    end
  end

  assign busy = (state != IDLE) | (|pending);

endmodule

// File: tb/tb_lane_judge_scheduler.sv
// Directed bench for lane_judge_scheduler: table of single-press transactions plus
// hand sequences for round-robin order, score_clear, saturation, dropped re-press and reset.
module tb_lane_judge_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        game_active, score_clear;
  logic [3:0]  btn_press, lane_valid;
  logic [39:0] lane_y;
  logic        score_req;
  logic [9:0]  score_y;
  logic [19:0] score_pts;
  logic [3:0]  arrow_clear;
  logic        hit_pulse, miss_pulse;
  logic [19:0] total_score;
  logic [9:0]  combo, max_combo;
  logic        busy;

  lane_judge_scheduler dut (
    .clk(clk), .rst(rst), .game_active(game_active), .score_clear(score_clear),
    .btn_press(btn_press), .lane_valid(lane_valid), .lane_y(lane_y),
    .score_req(score_req), .score_y(score_y), .score_pts(score_pts),
    .arrow_clear(arrow_clear), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .total_score(total_score), .combo(combo), .max_combo(max_combo), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scorer model: one-cycle registered response to score_req.
  logic [19:0] pts_resp;
  always @(posedge clk) score_pts <= score_req ? pts_resp : 20'd0;

  typedef struct {
    int         lane;
    bit         valid;
    int         y;
    int         pts;
    bit         exp_hit;
    logic [3:0] exp_clear;
    int         exp_total;
    int         exp_combo;
    int         exp_max;
  } vec_t;

  vec_t vecs [10];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int reqs, rk, pk, ry;
    logic ph, pm;
    logic [3:0] pc;
    reqs = 0; rk = -1; pk = -1; ry = -1; ph = 0; pm = 0; pc = 0;
    pts_resp = v.pts[19:0];
    @(negedge clk);
    btn_press  = 4'b0001 << v.lane;
    lane_valid = v.valid ? (4'b0001 << v.lane) : 4'b0000;
    lane_y[v.lane*10 +: 10] = v.y[9:0];
    @(negedge clk);
    btn_press  = 4'b0000;
    lane_valid = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      if (score_req) begin reqs++; rk = k; ry = int'(score_y); end
      if ((hit_pulse || miss_pulse) && pk < 0) begin
        pk = k; ph = hit_pulse; pm = miss_pulse; pc = arrow_clear;
      end
      if (k < 9) @(negedge clk);
    end
    chk("hit_pulse",  32'(ph), 32'(v.exp_hit));
    chk("miss_pulse", 32'(pm), 32'(!v.exp_hit));
    chk("arrow_clear", 32'(pc), 32'(v.exp_clear));
    chk("total", 32'(total_score), v.exp_total);
    chk("combo", 32'(combo), v.exp_combo);
    chk("max_combo", 32'(max_combo), v.exp_max);
    chk("req_count", reqs, v.valid ? 1 : 0);
    if (v.valid) begin
      chk("score_y", ry, v.y);
      chk("req_latency", rk, 1);
      chk("pulse_latency", pk, 4);
    end else begin
      chk("miss_latency", pk, 0);
    end
  endtask

  logic [3:0] clr_seen [4];
  int         cyc_seen [4];
  int         nseen;

  task automatic run_multi(input logic [3:0] mask);
    nseen = 0;
    pts_resp = 20'd1;
    @(negedge clk);
    btn_press  = mask;
    lane_valid = mask;
    @(negedge clk);
    btn_press  = 4'b0000;
    lane_valid = 4'b0000;
    for (int k = 0; k < 16; k++) begin
      if (arrow_clear != 4'b0000 && nseen < 4) begin
        clr_seen[nseen] = arrow_clear; cyc_seen[nseen] = k; nseen++;
      end
      if (k < 15) @(negedge clk);
    end
  endtask

  initial begin
    vecs[0] = '{2, 1, 398, 500, 1, 4'b0100, 500, 1, 1};
    vecs[1] = '{0, 1, 100, 250, 1, 4'b0001, 750, 2, 2};
    vecs[2] = '{3, 1,   7,   0, 0, 4'b0000, 750, 0, 2};
    vecs[3] = '{1, 1,  50,  10, 1, 4'b0010, 760, 1, 2};
    vecs[4] = '{0, 1,   1,   1, 1, 4'b0001, 761, 2, 2};
    vecs[5] = '{1, 1,   2,   1, 1, 4'b0010, 762, 3, 3};
    vecs[6] = '{2, 1,   3,   1, 1, 4'b0100, 763, 4, 4};
    vecs[7] = '{3, 1,   4,   1, 1, 4'b1000, 764, 5, 5};
    vecs[8] = '{1, 0,   9,   0, 0, 4'b0000, 764, 0, 5};
    vecs[9] = '{3, 1,   8,   0, 0, 4'b0000, 764, 0, 5};

    rst = 1'b1; game_active = 1'b1; score_clear = 1'b0;
    btn_press = '0; lane_valid = '0; lane_y = '0; pts_resp = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(score_req), 0);
    chk("rst_total", 32'(total_score), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pulses", 32'({hit_pulse, miss_pulse, arrow_clear}), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Round-robin: 0,1,3 -> ptr 0; then {0,2} -> 0,2 -> ptr 3; then {0,3} -> 3,0.
    run_multi(4'b1011);
    chk("rr1_n", nseen, 3);
    chk("rr1_g0", 32'(clr_seen[0]), 32'h1); chk("rr1_c0", cyc_seen[0], 4);
    chk("rr1_g1", 32'(clr_seen[1]), 32'h2); chk("rr1_c1", cyc_seen[1], 8);
    chk("rr1_g2", 32'(clr_seen[2]), 32'h8); chk("rr1_c2", cyc_seen[2], 12);
    run_multi(4'b0101);
    chk("rr2_n", nseen, 2);
    chk("rr2_g0", 32'(clr_seen[0]), 32'h1);
    chk("rr2_g1", 32'(clr_seen[1]), 32'h4);
    run_multi(4'b1001);
    chk("rr3_n", nseen, 2);
    chk("rr3_g0", 32'(clr_seen[0]), 32'h8);
    chk("rr3_g1", 32'(clr_seen[1]), 32'h1);
    chk("rr_total", 32'(total_score), 771);
    chk("rr_combo", 32'(combo), 7);
    chk("rr_max", 32'(max_combo), 7);

    @(negedge clk) score_clear = 1'b1;
    @(negedge clk) score_clear = 1'b0;
    chk("clr_total", 32'(total_score), 0);
    chk("clr_combo", 32'(combo), 0);
    chk("clr_max", 32'(max_combo), 0);

    run_vec('{0, 1, 20, 'hFFF00, 1, 4'b0001, 'hFFF00, 1, 1});

    // Saturation plus a re-press of the pending lane during its ACCUM cycle (must be dropped).
    begin
      int reqs, hits;
      reqs = 0; hits = 0;
      pts_resp = 20'd500;
      @(negedge clk);
      btn_press = 4'b0010; lane_valid = 4'b0010; lane_y[10 +: 10] = 10'd5;
      @(negedge clk);
      btn_press = 4'b0000;
      for (int k = 0; k < 12; k++) begin
        if (score_req) reqs++;
        if (hit_pulse) hits++;
        btn_press = (k == 3) ? 4'b0010 : 4'b0000;
        @(negedge clk);
      end
      lane_valid = 4'b0000;
      chk("sat_reqs", reqs, 1);
      chk("sat_hits", hits, 1);
      chk("sat_total", 32'(total_score), 32'hFFFFF);
      chk("sat_combo", 32'(combo), 2);
      chk("sat_busy", 32'(busy), 0);
    end

    // Reset while the scorer transaction is in WAIT.
    begin
      int evts;
      evts = 0;
      pts_resp = 20'd7;
      @(negedge clk);
      btn_press = 4'b0100; lane_valid = 4'b0100; lane_y[20 +: 10] = 10'd33;
      @(negedge clk);
      btn_press = 4'b0000; lane_valid = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_total", 32'(total_score), 0);
      chk("arst_combo", 32'(combo), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_outs", 32'({score_req, hit_pulse, miss_pulse, arrow_clear}), 0);
      @(negedge clk) rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (hit_pulse || miss_pulse || score_req) evts++;
        @(negedge clk);
      end
      chk("arst_no_events", evts, 0);
    end

    run_vec('{2, 1, 398, 500, 1, 4'b0100, 500, 1, 1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end
endmodule
